// File: rtl/bus_capture_pkg.sv
// bus_capture_pkg: shared types, constants and helper functions for the
// bus_capture block.
//   bus_state_t      per-cycle bus classification
//   CNT_W / CNT_MAX  width and saturation value of the error counters
//   onehot_to_index  index of the set bit of a (zero-extended) enable vector
//   popcount_ge2     true when two or more enable bits are set
package bus_capture_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SINGLE,
        BUS_CONFLICT
    } bus_state_t;

    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_MAX = 8'd255;

    // Enable vectors are zero-extended to the 16-driver maximum so one
    // function body serves every NUM_DRIVERS setting.
    function automatic logic [3:0] onehot_to_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if a second bit was set.
    function automatic logic popcount_ge2(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/bus_capture_fifo.sv
// bus_capture_fifo: parameterised synchronous show-ahead FIFO.
//   clk, rst (sync, active-low)
//   push/din   write request and data; accepted when not full, or when full
//              with a pop in the same cycle
//   pop        read request; ignored when empty
//   dout       head entry (zero while empty), full, empty status
// Pointers carry an extra wrap bit: equal -> empty, same index with differing
// wrap bit -> full.
module bus_capture_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so stale storage never shows.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && rst) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bus_capture.sv
// bus_capture: reader end of a shared tri-state switched bus.
// Each cycle the driver enable vector is classified as idle, single-driver
// or contention. Single-driver values are queued with their source index and
// drained through a valid/ready port; contention and FIFO overflow feed a
// sticky flag and two saturating counters.
//   clk, rst (sync, active-low)
//   bus_in, drv_en                     observed bus value and driver enables
//   out_data, out_src, out_valid       FIFO head; out_ready pops it
//   clr_err                            clears contention and both counters
//   contention, conflict_cnt, drop_cnt error reporting
// Optional: define BUS_CAPTURE_DEDUP_EN to suppress a SINGLE cycle whose
// {src,data} repeats the previous cycle's SINGLE capture.
module bus_capture
    import bus_capture_pkg::*;
#(
    parameter  int BIT_WIDTH   = 8,
    parameter  int NUM_DRIVERS = 4,
    parameter  int DEPTH       = 4,
    localparam int SRC_W       = $clog2(NUM_DRIVERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BIT_WIDTH-1:0]   bus_in,
    input  logic [NUM_DRIVERS-1:0] drv_en,
    output logic [BIT_WIDTH-1:0]   out_data,
    output logic [SRC_W-1:0]       out_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_err,
    output logic                   contention,
    output logic [CNT_W-1:0]       conflict_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    typedef struct packed {
        logic [SRC_W-1:0]     src;
        logic [BIT_WIDTH-1:0] data;
    } entry_t;

    bus_state_t  bus_state;
    logic [15:0] en16;
    logic [3:0]  idx_full;
    entry_t      cur, head;
    logic        dup, push_req, pop, full, empty, drop;

    assign en16     = 16'(drv_en);
    assign idx_full = onehot_to_index(en16);
    assign cur.src  = idx_full[SRC_W-1:0];
    assign cur.data = bus_in;

    always_comb begin
        bus_state = BUS_IDLE;
        if (popcount_ge2(en16))  bus_state = BUS_CONFLICT;
        else if (en16 != 16'd0)  bus_state = BUS_SINGLE;
    end

`ifdef BUS_CAPTURE_DEDUP_EN
    // Last SINGLE capture; any non-SINGLE cycle breaks the run.
    entry_t last_entry;
    logic   last_vld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_entry <= '0;
            last_vld   <= 1'b0;
        end else if (bus_state == BUS_SINGLE) begin
            last_entry <= cur;
            last_vld   <= 1'b1;
        end else begin
            last_vld   <= 1'b0;
        end
    end

    assign dup = last_vld && (last_entry == cur);
`else
    assign dup = 1'b0;
`endif

    assign pop      = out_valid && out_ready;
    assign push_req = (bus_state == BUS_SINGLE) && !dup;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign drop     = push_req && full && !pop;

    bus_capture_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (cur),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_data  = head.data;
    assign out_src   = head.src;

    // clr_err wins over increments, except that a same-cycle conflict is
    // still recorded as the first event after the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            contention   <= 1'b0;
            conflict_cnt <= '0;
            drop_cnt     <= '0;
        end else if (clr_err) begin
            contention   <= (bus_state == BUS_CONFLICT);
            conflict_cnt <= (bus_state == BUS_CONFLICT) ? CNT_W'(1) : '0;
            drop_cnt     <= '0;
        end else begin
            if (bus_state == BUS_CONFLICT) begin
                contention <= 1'b1;
                if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
            end
            if (drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_capture.sv
module tb_bus_capture;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic [3:0] drv_en;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       out_valid;
    logic       out_ready;
    logic       clr_err;
    logic       contention;
    logic [7:0] conflict_cnt;
    logic [7:0] drop_cnt;

    int npass = 0;
    int ntotal = 0;

    bus_capture #(.BIT_WIDTH(8), .NUM_DRIVERS(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_in       (bus_in),
        .drv_en       (drv_en),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .clr_err      (clr_err),
        .contention   (contention),
        .conflict_cnt (conflict_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; drv_en = 4'b0010; bus_in = 8'hAA;
        out_ready = 1'b0; clr_err = 1'b0;
        step(); step();
        rst = 1'b1; drv_en = 4'b0000;
        ntotal++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else npass++;
        ntotal++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else npass++;
        ntotal++; if (out_src !== 2'd0) $display("FAIL reset_src got %0d want 0", out_src); else npass++;
        ntotal++; if (contention !== 1'b0) $display("FAIL reset_contention got %0b want 0", contention); else npass++;
        ntotal++; if (conflict_cnt !== 8'd0) $display("FAIL reset_conflict_cnt got %0d want 0", conflict_cnt); else npass++;
        ntotal++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else npass++;
        step();
        ntotal++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %0b want 0", out_valid); else npass++;
    endtask

    task automatic test_single();
        out_ready = 1'b1; drv_en = 4'b0100; bus_in = 8'h5C;
        step();
        drv_en = 4'b0000;
        ntotal++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", out_valid); else npass++;
        ntotal++; if (out_src !== 2'd2) $display("FAIL single_src got %0d want 2", out_src); else npass++;
        ntotal++; if (out_data !== 8'h5C) $display("FAIL single_data got %h want 5c", out_data); else npass++;
        step();
        ntotal++; if (out_valid !== 1'b0) $display("FAIL single_popped got %0b want 0", out_valid); else npass++;
    endtask

    task automatic test_contention();
        drv_en = 4'b0011; bus_in = 8'h77;
        step(); step(); step();
        drv_en = 4'b0000;
        ntotal++; if (contention !== 1'b1) $display("FAIL cont_flag got %0b want 1", contention); else npass++;
        ntotal++; if (conflict_cnt !== 8'd3) $display("FAIL cont_cnt got %0d want 3", conflict_cnt); else npass++;
        ntotal++; if (out_valid !== 1'b0) $display("FAIL cont_no_entry got %0b want 0", out_valid); else npass++;
        clr_err = 1'b1; step(); clr_err = 1'b0;
        ntotal++; if (contention !== 1'b0) $display("FAIL clr_flag got %0b want 0", contention); else npass++;
        ntotal++; if (conflict_cnt !== 8'd0) $display("FAIL clr_cnt got %0d want 0", conflict_cnt); else npass++;
        // Clear together with a conflict: the conflict is recorded afresh.
        drv_en = 4'b1100; step();
        clr_err = 1'b1; step(); clr_err = 1'b0; drv_en = 4'b0000;
        ntotal++; if (contention !== 1'b1) $display("FAIL clr_conf_flag got %0b want 1", contention); else npass++;
        ntotal++; if (conflict_cnt !== 8'd1) $display("FAIL clr_conf_cnt got %0d want 1", conflict_cnt); else npass++;
        clr_err = 1'b1; step(); clr_err = 1'b0;
        ntotal++; if (conflict_cnt !== 8'd0) $display("FAIL clr2_cnt got %0d want 0", conflict_cnt); else npass++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'd2; exp_q[1] = 8'd3; exp_q[2] = 8'd4; exp_q[3] = 8'd7;
        out_ready = 1'b0; drv_en = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            bus_in = 8'(i);
            step();
        end
        drv_en = 4'b0000;
        ntotal++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop got %0d want 2", drop_cnt); else npass++;
        ntotal++; if (out_data !== 8'd1) $display("FAIL ovf_head got %0d want 1", out_data); else npass++;
        step();
        ntotal++; if (out_data !== 8'd1) $display("FAIL ovf_hold got %0d want 1", out_data); else npass++;
        // Push with a simultaneous pop while full: no drop.
        out_ready = 1'b1; drv_en = 4'b0001; bus_in = 8'd7;
        step();
        drv_en = 4'b0000;
        ntotal++; if (drop_cnt !== 8'd2) $display("FAIL ovf_pushpop_drop got %0d want 2", drop_cnt); else npass++;
        for (int i = 0; i < 4; i++) begin
            ntotal++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i] || out_src !== 2'd0)
                $display("FAIL ovf_drain%0d got v=%0b d=%0d s=%0d want v=1 d=%0d s=0", i, out_valid, out_data, out_src, exp_q[i]);
            else npass++;
            step();
        end
        ntotal++; if (out_valid !== 1'b0) $display("FAIL ovf_empty got %0b want 0", out_valid); else npass++;
        clr_err = 1'b1; step(); clr_err = 1'b0;
        ntotal++; if (drop_cnt !== 8'd0) $display("FAIL ovf_clr got %0d want 0", drop_cnt); else npass++;
    endtask

    task automatic test_saturation();
        drv_en = 4'b1111;
        for (int i = 0; i < 300; i++) step();
        ntotal++; if (conflict_cnt !== 8'd255) $display("FAIL sat_cnt got %0d want 255", conflict_cnt); else npass++;
        for (int i = 0; i < 5; i++) step();
        drv_en = 4'b0000;
        ntotal++; if (conflict_cnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", conflict_cnt); else npass++;
        ntotal++; if (contention !== 1'b1) $display("FAIL sat_flag got %0b want 1", contention); else npass++;
        clr_err = 1'b1; step(); clr_err = 1'b0;
        ntotal++; if (conflict_cnt !== 8'd0) $display("FAIL sat_clr got %0d want 0", conflict_cnt); else npass++;
    endtask

    task automatic test_dedup();
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        logic       src_ok;
`ifdef BUS_CAPTURE_DEDUP_EN
        exp_q = '{8'h11, 8'h22};
`else
        exp_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22};
`endif
        src_ok = 1'b1;
        out_ready = 1'b1;
        // With ready held high each entry is visible for exactly one cycle.
        for (int i = 0; i < 10; i++) begin
            drv_en = (i < 6) ? 4'b1000 : 4'b0000;
            bus_in = (i < 5) ? 8'h11 : 8'h22;
            step();
            if (out_valid) begin
                got_q.push_back(out_data);
                if (out_src !== 2'd3) src_ok = 1'b0;
            end
        end
        drv_en = 4'b0000;
        ntotal++; if (got_q.size() != exp_q.size()) $display("FAIL dedup_count got %0d want %0d", got_q.size(), exp_q.size()); else npass++;
        ntotal++; if (src_ok !== 1'b1) $display("FAIL dedup_src got bad want 3"); else npass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            ntotal++;
            if (got_q[i] !== exp_q[i]) $display("FAIL dedup_entry%0d got %h want %h", i, got_q[i], exp_q[i]);
            else npass++;
        end
        ntotal++; if (drop_cnt !== 8'd0) $display("FAIL dedup_drop got %0d want 0", drop_cnt); else npass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; drv_en = 4'b0010; bus_in = 8'h3C;
        step();
        bus_in = 8'h3D; step();
        drv_en = 4'b0000;
        ntotal++; if (out_valid !== 1'b1) $display("FAIL mid_prefill got %0b want 1", out_valid); else npass++;
        rst = 1'b0; step(); rst = 1'b1;
        ntotal++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL mid_reset got v=%0b d=%h want v=0 d=00", out_valid, out_data); else npass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_saturation();
        test_dedup();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
